// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdes_pkg
// Description : Shared definitions for the serializer/deserializer pair.
//               The FSM state encodings are shared with the receiver side.
// Revision    : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    typedef logic [0:0] state_t;

    localparam state_t c_ST_IDLE  = 1'b0;
    localparam state_t c_ST_SHIFT = 1'b1;

endpackage : serdes_pkg
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out shifter. It sends the word MSB first
//               and advances one bit per shift strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int SIZE = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [SIZE-1:0] p_in,
    input  logic            shift,
    output logic            s_out,
    output logic            s_valid,
    output logic            done
);

    localparam int c_CNT_W = $clog2(SIZE + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SIZE-1:0]     r_shreg;
    logic [SIZE-1:0]     w_shreg_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_done;
    logic                w_done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (load_valid) begin
                    w_state_nxt = c_ST_SHIFT;
                    w_shreg_nxt = p_in;
                    w_cnt_nxt   = c_CNT_W'(SIZE);
                end
            end
            c_ST_SHIFT: begin
                if (shift) begin
                    w_shreg_nxt = {r_shreg[SIZE-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt - c_CNT_W'(1);
                    // Last bit consumed: the register has been fully shifted
                    // out, so s_out returns to 0 in IDLE without extra gating.
                    if (r_cnt == c_CNT_W'(1)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign load_ready = (r_state == c_ST_IDLE);
    assign s_valid    = (r_state == c_ST_SHIFT);
    assign s_out      = r_shreg[SIZE-1];
    assign done       = r_done;

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer (SIZE=8 and SIZE=256).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       lv8, lr8, sh8, so8, sv8, dn8;
    logic [7:0] p8;

    logic         lv256, lr256, sh256, so256, sv256, dn256;
    logic [255:0] p256;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.SIZE(8)) u_dut8 (
        .clk(clk), .reset(reset), .load_valid(lv8), .load_ready(lr8),
        .p_in(p8), .shift(sh8), .s_out(so8), .s_valid(sv8), .done(dn8)
    );

    piso_serializer #(.SIZE(256)) u_dut256 (
        .clk(clk), .reset(reset), .load_valid(lv256), .load_ready(lr256),
        .p_in(p256), .shift(sh256), .s_out(so256), .s_valid(sv256), .done(dn256)
    );

    // Output vector order everywhere: {load_ready, s_valid, s_out, done}
    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({lr8, sv8, so8, dn8} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_async got %b exp %b", {lr8, sv8, so8, dn8}, 4'b1000);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({lr8, sv8, so8, dn8, lr256, sv256, so256, dn256} !== 8'b1000_1000) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b exp %b", c,
                         {lr8, sv8, so8, dn8, lr256, sv256, so256, dn256}, 8'b1000_1000);
            end
            sh8   = 1'($urandom_range(0, 1));
            sh256 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        sh8   = 1'b0;
        sh256 = 1'b0;
    endtask

    task automatic test_single_word();
        logic seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        lv8 = 1'b1; p8 = 8'hA5; sh8 = 1'b1;
        @(negedge clk);
        lv8 = 1'b0; p8 = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({lr8, sv8, so8, dn8} !== {1'b0, 1'b1, seq[k], 1'b0}) begin
                errors++;
                $display("FAIL single_bit %0d got %b exp %b", k, {lr8, sv8, so8, dn8},
                         {1'b0, 1'b1, seq[k], 1'b0});
            end
            @(negedge clk);
        end
        checks++;
        if ({lr8, sv8, so8, dn8} !== 4'b1001) begin
            errors++;
            $display("FAIL single_done got %b exp %b", {lr8, sv8, so8, dn8}, 4'b1001);
        end
        sh8 = 1'b0;
        @(negedge clk);
        checks++;
        if ({lr8, sv8, so8, dn8} !== 4'b1000) begin
            errors++;
            $display("FAIL single_done_width got %b exp %b", {lr8, sv8, so8, dn8}, 4'b1000);
        end
    endtask

    task automatic test_stalled_shift();
        logic seq [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   acc     = 0;
        bit   got_done = 1'b0;
        @(negedge clk);
        lv8 = 1'b1; p8 = 8'h3C; sh8 = 1'b0;
        @(negedge clk);
        lv8 = 1'b0;
        for (int c = 0; c < 100 && !got_done; c++) begin
            checks++;
            if (acc == 8) begin
                got_done = 1'b1;
                if ({lr8, sv8, so8, dn8} !== 4'b1001) begin
                    errors++;
                    $display("FAIL stall_done got %b exp %b", {lr8, sv8, so8, dn8}, 4'b1001);
                end
                sh8 = 1'b0;
            end else begin
                if ({lr8, sv8, so8, dn8} !== {1'b0, 1'b1, seq[acc], 1'b0}) begin
                    errors++;
                    $display("FAIL stall_bit cyc %0d acc %0d got %b exp %b", c, acc,
                             {lr8, sv8, so8, dn8}, {1'b0, 1'b1, seq[acc], 1'b0});
                end
                sh8 = pat[c % 4];
                if (sh8) acc++;
            end
            @(negedge clk);
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout got acc %0d exp done", acc);
        end
        sh8 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2] = '{8'hFF, 8'h01};
        logic [3:0] exp;
        int         nbits = 0;
        int         ndone = 0;
        @(negedge clk);
        lv8 = 1'b1; p8 = words[0]; sh8 = 1'b1;
        @(negedge clk);
        p8 = words[1];
        for (int i = 0; i < 18; i++) begin
            if (i == 8 || i == 17) begin
                exp = 4'b1001;
            end else begin
                exp = {1'b0, 1'b1, words[i / 9][7 - (i % 9)], 1'b0};
            end
            checks++;
            if ({lr8, sv8, so8, dn8} !== exp) begin
                errors++;
                $display("FAIL b2b cyc %0d got %b exp %b", i, {lr8, sv8, so8, dn8}, exp);
            end
            if (sv8 === 1'b1) nbits++;
            if (dn8 === 1'b1) ndone++;
            if (i == 17) lv8 = 1'b0;
            @(negedge clk);
        end
        sh8 = 1'b0;
        checks++;
        if (nbits != 16 || ndone != 2 || {lr8, sv8, dn8} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_totals got bits %0d done %0d exp bits 16 done 2", nbits, ndone);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w2 = 8'h81;
        @(negedge clk);
        lv8 = 1'b1; p8 = 8'hC3; sh8 = 1'b0;
        @(negedge clk);
        lv8 = 1'b0; sh8 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({lr8, sv8, so8, dn8} !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_pre got %b exp %b", {lr8, sv8, so8, dn8}, 4'b0100);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({lr8, sv8, so8, dn8} !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_async got %b exp %b", {lr8, sv8, so8, dn8}, 4'b1000);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) reset = 1'b0;
            checks++;
            if ({lr8, sv8, so8, dn8} !== 4'b1000) begin
                errors++;
                $display("FAIL midrst_nodone cyc %0d got %b exp %b", c, {lr8, sv8, so8, dn8}, 4'b1000);
            end
        end
        lv8 = 1'b1; p8 = w2;
        @(negedge clk);
        lv8 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (k < 8 && {lr8, sv8, so8, dn8} !== {1'b0, 1'b1, w2[7 - k], 1'b0}) begin
                errors++;
                $display("FAIL midrst_reload bit %0d got %b exp %b", k, {lr8, sv8, so8, dn8},
                         {1'b0, 1'b1, w2[7 - k], 1'b0});
            end else if (k == 8 && {lr8, sv8, so8, dn8} !== 4'b1001) begin
                errors++;
                $display("FAIL midrst_reload_done got %b exp %b", {lr8, sv8, so8, dn8}, 4'b1001);
            end
            @(negedge clk);
        end
        sh8 = 1'b0;
    endtask

    // Transaction model: a word is "in flight" with n bits already consumed.
    task automatic test_random();
        bit         busy     = 1'b0;
        bit         done_exp = 1'b0;
        logic [7:0] word     = '0;
        int         n        = 0;
        logic [3:0] exp;
        @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            exp = {!busy, busy, busy ? word[7 - n] : 1'b0, done_exp};
            checks++;
            if ({lr8, sv8, so8, dn8} !== exp) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", c, {lr8, sv8, so8, dn8}, exp);
            end
            lv8 = 1'($urandom_range(0, 3) == 0);
            p8  = 8'($urandom);
            sh8 = 1'($urandom_range(0, 2) != 0);
            done_exp = 1'b0;
            if (!busy) begin
                if (lv8) begin
                    busy = 1'b1; word = p8; n = 0;
                end
            end else if (sh8) begin
                n++;
                if (n == 8) begin
                    busy = 1'b0; done_exp = 1'b1;
                end
            end
            @(negedge clk);
        end
        lv8 = 1'b0; sh8 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [255:0] w;
        logic [255:0] rx;
        bit           seen;
        for (int t = 0; t < 50; t++) begin
            for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
            rx = '0;
            @(negedge clk);
            lv256 = 1'b1; p256 = w; sh256 = 1'b0;
            @(negedge clk);
            lv256 = 1'b0; p256 = '0;
            seen = 1'b0;
            for (int c = 0; c < 2000 && !seen; c++) begin
                if (dn256 === 1'b1) begin
                    seen = 1'b1;
                    sh256 = 1'b0;
                    checks++;
                    if (rx !== w) begin
                        errors++;
                        $display("FAIL loopback word %0d got %h exp %h", t, rx, w);
                    end
                end else begin
                    sh256 = 1'($urandom_range(0, 3) != 0);
                    if (sh256 && sv256) rx = {rx[254:0], so256};
                end
                @(negedge clk);
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL loopback_timeout word %0d got no done exp done", t);
                sh256 = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        lv8 = 1'b0; sh8 = 1'b0; p8 = '0;
        lv256 = 1'b0; sh256 = 1'b0; p256 = '0;
        test_reset();
        test_single_word();
        test_stalled_shift();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_piso_serializer
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter SIZE, default 256, meaning the parallel word width in bits (legal range 2..1024).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load_valid  input  1  producer offers p_in for serialization.
REQ-005 SHALL have port load_ready  output  1  block can accept a new word.
REQ-006 SHALL have port p_in  input  SIZE  parallel word to transmit.
REQ-007 SHALL have port shift  input  1  consumer advances the serial stream by one bit this cycle.
REQ-008 SHALL have port s_out  output  1  current serial bit.
REQ-009 SHALL have port s_valid  output  1  s_out carries a valid bit of the current word.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last bit of a word is consumed.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 In IDLE, load_ready SHALL be 1, s_valid 0, s_out 0; shift SHALL be ignored.
REQ-013 Load handshake: when load_valid=1 and load_ready=1 at a rising edge, the block SHALL capture p_in into a SIZE-bit shift register, set bit counter to SIZE, and enter SHIFT.
REQ-014 load_valid while load_ready=0 SHALL have no effect; p_in is sampled only at the handshake edge.
REQ-015 In SHIFT, load_ready SHALL be 0, s_valid 1, and s_out SHALL equal shift-register bit SIZE-1 (MSB first), driven directly from a register (no combinational path from inputs).
REQ-016 Each rising edge with shift=1 in SHIFT SHALL shift the register left by one (zero into bit 0) and decrement the counter by one.
REQ-017 shift=0 in SHIFT SHALL hold register, counter and s_out unchanged indefinitely.
REQ-018 When shift=1 with counter=1, the block SHALL return to IDLE and assert done for exactly the next cycle.
REQ-019 Latency: first bit SHALL be valid on s_out the cycle after the load handshake; a word SHALL take exactly SIZE accepted shift cycles.
REQ-020 Back-to-back: load_ready SHALL rise in the same cycle done is asserted, so the minimum gap between words is one cycle.
REQ-021 Counter width SHALL be clog2(SIZE+1) bits; it never wraps below 0 (transition to IDLE at 1).
REQ-022 Bit order SHALL match the team's SIPO receiver: feeding s_out into a SIZE-bit left-shifting serial-in register with the same shift strobe reconstructs p_in exactly.

Reset
REQ-023 Asserting reset SHALL immediately force IDLE, clear shift register and counter, and drive load_ready=1, s_valid=0, s_out=0, done=0.
REQ-024 Reset during SHIFT SHALL abort the word with no done pulse; partial data is discarded.
REQ-025 After reset deassertion the first handshake edge SHALL behave exactly as REQ-013.

Structure
REQ-026 The FSM state encodings (IDLE=0, SHIFT=1) SHALL be defined as constants in a shared package serdes_pkg, also available to the receiver side.
REQ-027 The block SHALL be a single module with no sub-modules; counter, FSM and shift register are inline.

Verification (bench SIZE=8 unless noted)
REQ-028 Reset then idle: reset 1->0, no stimulus -> load_ready=1, s_valid=0, s_out=0, done=0 for 20 cycles; shift pulses ignored.
REQ-029 Single word: load 8'hA5, shift held 1 -> s_out sequence 1,0,1,0,0,1,0,1 over 8 cycles, done pulses once on cycle 9, load_ready=1 same cycle.
REQ-030 Stalled shift: load 8'h3C, shift toggles 1,0,0,1,... -> s_out holds during shift=0, same 8-bit sequence 0,0,1,1,1,1,0,0, done after 8th accepted shift.
REQ-031 Back-to-back: load_valid held 1 with words 8'hFF then 8'h01, shift=1 -> 16 valid bits with exactly one idle cycle between words, two done pulses.
REQ-032 Reset mid-word: load 8'hC3, reset asserted after 3 shifts -> outputs return to reset values asynchronously, no done; next load 8'h81 transmits correctly.
REQ-033 Loopback, SIZE=256: 50 random words into a 256-bit serial-in receiver on shift -> received word equals p_in at every done.
